game_timer_ctrl: RTL and testbench

Sequencing controller for the game's countdown timer chain. Starts, pauses, resumes, stops and reloads the prescaler chain (100 ms tick → 1 s tick). Counts the round's seconds down from a loaded value and reports remaining time and expiry to the game FSM. Sits between the game FSM (start/pause/stop commands) and the prescaler chain (enable/clear out, 1 s tick in).

---
 rtl/game_timer_pkg.sv | 15 +
 rtl/game_timer_ctrl_if.sv | 27 ++
 rtl/sec_downcounter.sv | 31 +++
 rtl/game_timer_ctrl.sv | 132 +++++++++++++
 tb/tb_game_timer_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/game_timer_pkg.sv
// Shared definitions for the game countdown timer: state encoding and default sizing.
package game_timer_pkg;

  localparam int SEC_W        = 7;
  localparam int DEFAULT_SECS = 120;
  localparam int WARN_SECS    = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Command/status bundle between the game FSM, the prescaler chain and the timer controller.
// master = game FSM / prescaler side, slave = game_timer_ctrl.
interface game_timer_ctrl_if #(
  parameter int SEC_W = game_timer_pkg::SEC_W
);
  logic             start;
  logic             pause;
  logic             stop;
  logic [SEC_W-1:0] load_secs;
  logic             one_sec_tick;
  logic             tick_en;
  logic             prescaler_clr;
  logic [SEC_W-1:0] seconds_left;
  logic             running;
  logic             expired;
  logic             warn;

  modport master (
    output start, pause, stop, load_secs, one_sec_tick,
    input  tick_en, prescaler_clr, seconds_left, running, expired, warn
  );

  modport slave (
    input  start, pause, stop, load_secs, one_sec_tick,
    output tick_en, prescaler_clr, seconds_left, running, expired, warn
  );
endinterface

// File: rtl/sec_downcounter.sv
// Loadable seconds down-counter that saturates at zero instead of wrapping.
// zero_next flags that the next decrement lands on zero.
module sec_downcounter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero_next
);

  logic [W-1:0] count_reg;

  // load wins over dec; dec at zero holds so the count never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign count     = count_reg;
  assign zero_next = (count_reg == W'(1));

endmodule

// File: rtl/game_timer_ctrl.sv
// Round timer sequencer: drives the prescaler chain and counts seconds down.
// Optional low-time warning output is built only when GAME_TIMER_WARN_EN is defined.
module game_timer_ctrl #(
  parameter int SEC_W        = game_timer_pkg::SEC_W,
  parameter int DEFAULT_SECS = game_timer_pkg::DEFAULT_SECS,
  parameter int WARN_SECS    = game_timer_pkg::WARN_SECS
) (
  input logic              clk,
  input logic              rst,
  game_timer_ctrl_if.slave bus
);
  import game_timer_pkg::*;

  localparam logic [SEC_W-1:0] DEFAULT_VAL = SEC_W'(DEFAULT_SECS);

  state_t           state_reg, state_next;
  logic             tick_en_reg, running_reg, clr_reg, expired_reg;
  logic             clr_next, expired_next;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [SEC_W-1:0] cnt, load_val;

  assign load_val = (bus.load_secs == '0) ? DEFAULT_VAL : bus.load_secs;

  sec_downcounter #(.W(SEC_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_val  (load_val),
    .dec       (cnt_dec),
    .count     (cnt),
    .zero_next (cnt_is_one)
  );

  // Next state and counter controls; priority stop > tick > start > pause
  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    clr_next     = 1'b0;
    expired_next = 1'b0;
    if (bus.stop) begin
      state_next = IDLE;
      clr_next   = 1'b1;
    end else begin
      case (state_reg)
        IDLE, EXPIRED: begin
          if (bus.start) begin
            state_next = RUN;
            cnt_load   = 1'b1;
            clr_next   = 1'b1;
          end
        end
        RUN: begin
          if (bus.one_sec_tick) begin
            // the tick is counted first; expiry beats a simultaneous pause
            cnt_dec = 1'b1;
            if (cnt_is_one) begin
              state_next   = EXPIRED;
              expired_next = 1'b1;
            end else if (bus.pause) begin
              state_next = PAUSED;
            end
          end else if (bus.pause) begin
            state_next = PAUSED;
          end
        end
        PAUSED: begin
          // resume keeps the prescaler's partial second: no reload, no clear
          if (bus.start) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and registered outputs; tick_en waits one cycle behind a prescaler clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_en_reg <= 1'b0;
      running_reg <= 1'b0;
      clr_reg     <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tick_en_reg <= (state_next == RUN) && !clr_next;
      running_reg <= (state_next == RUN);
      clr_reg     <= clr_next;
      expired_reg <= expired_next;
    end
  end

  assign bus.tick_en       = tick_en_reg;
  assign bus.running       = running_reg;
  assign bus.prescaler_clr = clr_reg;
  assign bus.expired       = expired_reg;
  assign bus.seconds_left  = cnt;

`ifdef GAME_TIMER_WARN_EN
  localparam logic [SEC_W-1:0] WARN_VAL = SEC_W'(WARN_SECS);

  logic             warn_reg;
  logic [SEC_W-1:0] cnt_next;

  // Mirror of the counter's next value so warn lines up with seconds_left
  always_comb begin
    cnt_next = cnt;
    if (cnt_load) begin
      cnt_next = load_val;
    end else if (cnt_dec && (cnt != '0)) begin
      cnt_next = cnt - SEC_W'(1);
    end
  end

  // Warning only while a round is live (running or paused) and time is low
  always_ff @(posedge clk) begin
    if (rst) begin
      warn_reg <= 1'b0;
    end else begin
      warn_reg <= ((state_next == RUN) || (state_next == PAUSED)) &&
                  (cnt_next != '0) && (cnt_next <= WARN_VAL);
    end
  end

  assign bus.warn = warn_reg;
`else
  assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl; warn checks depend on GAME_TIMER_WARN_EN.
module tb_game_timer_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  game_timer_ctrl_if #(.SEC_W(7)) bus ();

  game_timer_ctrl #(
    .SEC_W(7), .DEFAULT_SECS(120), .WARN_SECS(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("chk %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic tick();
    bus.one_sec_tick = 1'b1;
    cyc();
    bus.one_sec_tick = 1'b0;
  endtask

  task automatic do_start(input int secs);
    bus.load_secs = 7'(secs);
    bus.start     = 1'b1;
    cyc();
    bus.start     = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.stop = 0;
    bus.load_secs = 0; bus.one_sec_tick = 0;
    idle(2);
    rst = 1'b0;
    #1;
    chk("rst_secs", bus.seconds_left, 0);
    chk("rst_tick_en", bus.tick_en, 0);
    chk("rst_clr", bus.prescaler_clr, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_expired", bus.expired, 0);
    chk("rst_warn", bus.warn, 0);

    // countdown from 3 with a tick every 10 cycles
    do_start(3);
    chk("s3_secs", bus.seconds_left, 3);
    chk("s3_clr", bus.prescaler_clr, 1);
    chk("s3_tick_en0", bus.tick_en, 0);
    chk("s3_running", bus.running, 1);
    cyc();
    chk("s3_clr_off", bus.prescaler_clr, 0);
    chk("s3_tick_en1", bus.tick_en, 1);
    idle(8); tick();
    chk("s3_secs2", bus.seconds_left, 2);
    chk("s3_noexp", bus.expired, 0);
    idle(9); tick();
    chk("s3_secs1", bus.seconds_left, 1);
    idle(9); tick();
    chk("s3_secs0", bus.seconds_left, 0);
    chk("s3_expired", bus.expired, 1);
    chk("s3_tick_en_dn", bus.tick_en, 0);
    chk("s3_run_dn", bus.running, 0);
    cyc();
    chk("s3_exp_pulse", bus.expired, 0);
    chk("s3_hold0", bus.seconds_left, 0);
    tick();
    chk("exp_tick_ign", bus.seconds_left, 0);

    // restart from EXPIRED with default length
    do_start(0);
    chk("def_secs", bus.seconds_left, 120);
    chk("def_clr", bus.prescaler_clr, 1);
    chk("def_tick_en0", bus.tick_en, 0);
    cyc();
    chk("def_clr_off", bus.prescaler_clr, 0);
    chk("def_tick_en1", bus.tick_en, 1);

    // stop from RUN then pause/resume at 50
    do_stop();
    chk("stp_secs", bus.seconds_left, 120);
    chk("stp_clr", bus.prescaler_clr, 1);
    do_start(50);
    cyc();
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    chk("pz_running", bus.running, 0);
    chk("pz_tick_en", bus.tick_en, 0);
    for (int i = 0; i < 5; i++) begin tick(); idle(2); end
    chk("pz_hold", bus.seconds_left, 50);
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    chk("pz_pause_ign", bus.running, 0);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("rs_running", bus.running, 1);
    chk("rs_tick_en", bus.tick_en, 1);
    chk("rs_clr", bus.prescaler_clr, 0);
    chk("rs_secs", bus.seconds_left, 50);
    tick();
    chk("rs_secs49", bus.seconds_left, 49);

    // tick and pause together at 5, then at 1
    do_stop();
    do_start(5);
    cyc();
    bus.pause = 1'b1; bus.one_sec_tick = 1'b1; cyc();
    bus.pause = 1'b0; bus.one_sec_tick = 1'b0;
    chk("tp5_secs", bus.seconds_left, 4);
    chk("tp5_running", bus.running, 0);
    chk("tp5_expired", bus.expired, 0);
    bus.load_secs = 7'd9;
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("tp5_resume", bus.seconds_left, 4);
    chk("tp5_no_clr", bus.prescaler_clr, 0);
    tick(); tick(); tick();
    chk("tp1_secs", bus.seconds_left, 1);
    bus.pause = 1'b1; bus.one_sec_tick = 1'b1; cyc();
    bus.pause = 1'b0; bus.one_sec_tick = 1'b0;
    chk("tp1_secs0", bus.seconds_left, 0);
    chk("tp1_expired", bus.expired, 1);
    chk("tp1_running", bus.running, 0);
    cyc();
    chk("tp1_pulse", bus.expired, 0);

    // stop at 30: hold value, ignore later ticks
    do_start(30);
    cyc();
    do_stop();
    chk("st30_secs", bus.seconds_left, 30);
    chk("st30_tick_en", bus.tick_en, 0);
    chk("st30_clr", bus.prescaler_clr, 1);
    chk("st30_running", bus.running, 0);
    tick();
    chk("st30_ign", bus.seconds_left, 30);
    chk("st30_clr_off", bus.prescaler_clr, 0);

    // start held through RUN and across expiry
    bus.load_secs = 7'd1; bus.start = 1'b1;
    cyc();
    chk("hold_secs1", bus.seconds_left, 1);
    cyc();
    chk("hold_no_rl", bus.prescaler_clr, 0);
    tick();
    chk("hold_exp", bus.expired, 1);
    cyc();
    chk("hold_restart", bus.seconds_left, 1);
    chk("hold_rclr", bus.prescaler_clr, 1);
    chk("hold_rexp", bus.expired, 0);
    bus.start = 1'b0;

    // warn window on a countdown from 12, then reset mid-round
    do_stop();
    do_start(12);
    chk("w12_warn", bus.warn, 0);
    cyc();
    tick();
    chk("w11_warn", bus.warn, 0);
    tick();
    chk("w10_secs", bus.seconds_left, 10);
`ifdef GAME_TIMER_WARN_EN
    chk("w10_warn", bus.warn, 1);
`else
    chk("w10_warn_off", bus.warn, 0);
`endif
    tick(); tick(); tick();
    bus.pause = 1'b1; cyc(); bus.pause = 1'b0;
    chk("w7_secs", bus.seconds_left, 7);
`ifdef GAME_TIMER_WARN_EN
    chk("w7_warn_pz", bus.warn, 1);
`else
    chk("w7_warn_off", bus.warn, 0);
`endif
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mr_secs", bus.seconds_left, 0);
    chk("mr_tick_en", bus.tick_en, 0);
    chk("mr_running", bus.running, 0);
    chk("mr_clr", bus.prescaler_clr, 0);
    chk("mr_expired", bus.expired, 0);
    chk("mr_warn", bus.warn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
